// File: rtl/io_pkg.sv
// Shared definitions for the IO-region peripherals.
//   - Register offsets decoded from addressIN[1:0].
//   - STATUS and CTRL bit positions.
//   - Serial FSM state encoding shared by the TX and RX engines.
package io_pkg;

  localparam logic [1:0] IO_TXDATA = 2'b00;
  localparam logic [1:0] IO_RXDATA = 2'b01;
  localparam logic [1:0] IO_STATUS = 2'b10;
  localparam logic [1:0] IO_CTRL   = 2'b11;

  localparam int unsigned STAT_TX_FULL  = 0;
  localparam int unsigned STAT_TX_EMPTY = 1;
  localparam int unsigned STAT_RX_VALID = 2;
  localparam int unsigned STAT_RX_OVR   = 3;
  localparam int unsigned STAT_TX_BUSY  = 4;
  localparam int unsigned STAT_LOOPBACK = 5;

  localparam int unsigned CTRL_POP_RX   = 0;
  localparam int unsigned CTRL_CLR_OVR  = 1;
  localparam int unsigned CTRL_LOOPBACK = 2;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StData  = 2'b10,
    StStop  = 2'b11
  } uart_state_e;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous single-clock FIFO with first-word fall-through read data.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset (pointers only)
//   push, wdata    - write request and data; ignored while full
//   pop, rdata     - read request; rdata shows the head entry whenever not empty
//   full, empty    - occupancy flags
// DEPTH must be a power of two and at least 2.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_uart_port.sv
// Memory-mapped UART in the IO region (8N1, fixed baud).
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   IOdata_wrEn  - controller write strobe
//   addressIN    - IO offset; only [1:0] is decoded, upper bits alias
//   IOdata_IN    - write data
//   IOdata_OUT   - registered read data, valid one cycle after the address
//   uart_rx      - serial input (asynchronous, idle high)
//   uart_tx      - serial output (idle high)
//   irq          - RX byte valid or RX overrun
// Register map: 0 TXDATA (W), 1 RXDATA (R), 2 STATUS (R), 3 CTRL (W, self-clearing).
// Build option: define IO_UART_LOOPBACK_EN to add CTRL bit2 / STATUS bit5 loopback,
// which feeds the internal uart_tx into the receiver in place of uart_rx.
// CLKS_PER_BIT must be at least 4; TX_DEPTH a power of two.
module io_uart_port
  import io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TX_DEPTH     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IOdata_wrEn,
  input  logic [13:0] addressIN,
  input  logic [7:0]  IOdata_IN,
  output logic [7:0]  IOdata_OUT,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic [1:0] reg_sel;
  logic       wr_tx, wr_ctrl, pop_rx, clr_ovr;
  logic       unused_addr;

  assign reg_sel     = addressIN[1:0];
  assign unused_addr = ^addressIN[13:2];
  assign wr_tx       = IOdata_wrEn && (reg_sel == IO_TXDATA);
  assign wr_ctrl     = IOdata_wrEn && (reg_sel == IO_CTRL);
  assign pop_rx      = wr_ctrl && IOdata_IN[CTRL_POP_RX];
  assign clr_ovr     = wr_ctrl && IOdata_IN[CTRL_CLR_OVR];

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0] fifo_rdata;
  logic       fifo_full, fifo_empty, fifo_pop;

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_tx),
    .wdata (IOdata_IN),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  uart_state_e      tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             tx_line_q;

  // The head is consumed in the same IDLE cycle that launches the start bit.
  assign fifo_pop = (tx_state_q == StIdle) && !fifo_empty;
  assign uart_tx  = tx_line_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      unique case (tx_state_q)
        StIdle: begin
          tx_line_q <= 1'b1;
          if (!fifo_empty) begin
            tx_shift_q <= fifo_rdata;
            tx_cnt_q   <= '0;
            tx_line_q  <= 1'b0;
            tx_state_q <= StStart;
          end
        end
        StStart: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_line_q  <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= StData;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_line_q  <= 1'b1;
              tx_state_q <= StStop;
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_line_q  <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= '0;
            tx_state_q <= StIdle;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX source selection
  // ---------------------------------------------------------------------------
  logic rx_src;
  logic loopback_bit;

`ifdef IO_UART_LOOPBACK_EN
  logic loopback_q;

  // Holds the last value written to CTRL bit2; not cleared by the self-clearing bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loopback_q <= 1'b0;
    end else if (wr_ctrl) begin
      loopback_q <= IOdata_IN[CTRL_LOOPBACK];
    end
  end

  assign rx_src       = loopback_q ? tx_line_q : uart_rx;
  assign loopback_bit = loopback_q;
`else
  assign rx_src       = uart_rx;
  assign loopback_bit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_src;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  uart_state_e      rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q, rx_ovr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      // Host clears first; a byte completing below overrides them in the same cycle.
      if (pop_rx)  rx_valid_q <= 1'b0;
      if (clr_ovr) rx_ovr_q   <= 1'b0;

      unique case (rx_state_q)
        StIdle: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_cnt_q   <= '0;
            rx_state_q <= StStart;
          end
        end
        StStart: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q <= '0;
            if (rx_sync_q) begin
              rx_state_q <= StIdle;  // line back high at mid-start: glitch
            end else begin
              rx_bit_q   <= '0;
              rx_state_q <= StData;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= StStop;
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= StIdle;
            // A low stop bit is a framing error: the byte is dropped silently.
            if (rx_sync_q) begin
              rx_data_q  <= rx_shift_q;
              rx_valid_q <= 1'b1;
              if (rx_valid_q && !pop_rx) rx_ovr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign irq = rx_valid_q || rx_ovr_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [7:0] status;

  always_comb begin
    status                = '0;
    status[STAT_TX_FULL]  = fifo_full;
    status[STAT_TX_EMPTY] = fifo_empty && (tx_state_q == StIdle);
    status[STAT_RX_VALID] = rx_valid_q;
    status[STAT_RX_OVR]   = rx_ovr_q;
    status[STAT_TX_BUSY]  = (tx_state_q != StIdle);
    status[STAT_LOOPBACK] = loopback_bit;
  end

  logic [7:0] rd_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      unique case (reg_sel)
        IO_TXDATA: rd_data_q <= '0;
        IO_RXDATA: rd_data_q <= rx_valid_q ? rx_data_q : 8'h00;
        IO_STATUS: rd_data_q <= status;
        IO_CTRL:   rd_data_q <= '0;
      endcase
    end
  end

  assign IOdata_OUT = rd_data_q;

endmodule

// File: doc/io_uart_port.md
Name: io_uart_port

Overview:
- Memory-mapped UART peripheral in the IO region (address bits [15:14] = 11).
- Consumes the memory controller's IO write data, IO write enable and 14-bit address.
- Returns 8-bit read data on the controller's IO read-data input.
- Contains a TX FIFO, a serial transmitter, a serial receiver with a one-deep holding register, and status/control registers.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per serial bit (50 MHz / 115200 baud); must be ≥ 4.
- TX_DEPTH, 16: TX FIFO entries; must be a power of 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- IOdata_wrEn  in  1  write strobe from the memory controller; a write occurs on any cycle it is high.
- addressIN  in  14  IO offset; only [1:0] decoded, [13:2] ignored (registers alias).
- IOdata_IN  in  8  write data from the controller.
- IOdata_OUT  out  8  registered read data to the controller.
- uart_rx  in  1  serial input, asynchronous, idle high.
- uart_tx  out  1  serial output, idle high.
- irq  out  1  high while RX data valid OR overrun.

Behaviour:
- Register map (addressIN[1:0]):
  - 00 TXDATA: write pushes a byte to the TX FIFO; read returns 0.
  - 01 RXDATA: read returns the held RX byte (0 if none).
  - 10 STATUS (read-only):
    - bit0 txFull; bit1 txEmpty (FIFO empty and shifter idle); bit2 rxValid; bit3 rxOverrun; bit4 txBusy.
    - bits7:5 read 0.
  - 11 CTRL (write-only, self-clearing, reads 0):
    - bit0 popRx: clears rxValid.
    - bit1 clrOvr: clears rxOverrun.
- Read latency:
  - IOdata_OUT is registered every cycle from addressIN[1:0] and the current state.
  - Data is valid 1 cycle after the address is presented, matching synchronous data RAM.
  - Reads have no side effects.
- Reset values:
  - uart_tx = 1, IOdata_OUT = 0, irq = 0.
  - FIFO empty; rxValid = 0, rxOverrun = 0.
  - TX and RX FSMs in IDLE; baud counters 0; RX synchronizer flops = 1.
- TX FIFO:
  - Pointer width log2(TX_DEPTH) + 1.
  - A push while full is dropped; the FIFO is unchanged.
  - A push and a pop in the same cycle are both honoured; count is unchanged.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if the FIFO is not empty, pop the head into the shift register and enter START.
  - START: uart_tx = 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: uart_tx = 1 for CLKS_PER_BIT cycles.
  - Back-to-back bytes: no idle gap beyond the 1-cycle IDLE decision.
  - txBusy = state ≠ IDLE.
- RX:
  - uart_rx passes through a 2-flop synchronizer.
  - FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a falling edge enters START.
  - START: sample at CLKS_PER_BIT/2. If the line is high there, it is a false start; return to IDLE.
  - DATA: sample each bit at mid-bit, LSB first.
  - STOP: sample at mid-bit.
    - Stop bit = 1: load the holding register. If rxValid was already set, the byte overwrites and rxOverrun is set. rxValid is then set.
    - Stop bit = 0 (framing error): discard the byte, flags unchanged.
  - Return to IDLE at the end of the stop sample; no half-bit wait.
- Simultaneous events:
  - Byte-complete and popRx in the same cycle: the new byte wins, rxValid = 1, no overrun set.
  - Overrun-set and clrOvr in the same cycle: set wins.
- IOdata_wrEn with an undefined address bit pattern cannot occur (all 4 offsets are decoded).
- Reset asserted mid-frame: uart_tx returns to 1 immediately and the partial byte is lost.

Optional Feature:
- IO_UART_LOOPBACK_EN defined:
  - CTRL bit2 becomes a sticky loopback enable (reset 0; STATUS bit5 reflects it).
  - When set, the RX input is the internal uart_tx instead of uart_rx.
  - uart_tx is still driven.
- Not defined:
  - CTRL bit2 is ignored and STATUS bit5 reads 0.
  - No mux is present on the RX input.

Decomposition:
- Shared package io_pkg holds:
  - register offset constants IO_TXDATA = 2'b00, IO_RXDATA = 2'b01, IO_STATUS = 2'b10, IO_CTRL = 2'b11;
  - STATUS bit indices;
  - TX/RX state encodings (2-bit: IDLE, START, DATA, STOP).
- One sub-module: io_sync_fifo (parameters WIDTH, DEPTH), used for the TX FIFO.
- TX and RX FSMs stay inline.

Test Plan:
- Reset, then read STATUS (addr 2): IOdata_OUT = 8'h02 one cycle later (txEmpty only); uart_tx = 1.
- Write 8'hA5 to addr 0 with CLKS_PER_BIT = 8: uart_tx shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 8 cycles; STATUS = 8'h02 after the stop bit.
- Write 17 bytes 8'h00..8'h10 back-to-back with TX_DEPTH = 16 while the shifter is busy: txFull (bit0) is set; the byte dropped is the one pushed while full; the serial stream omits exactly that byte.
- Drive serial 8'h3C on uart_rx: irq = 1, STATUS bit2 = 1, RXDATA reads 8'h3C; write 8'h01 to addr 3 → rxValid = 0, irq = 0.
- Receive 8'h11 then 8'h22 without popping: RXDATA = 8'h22, STATUS = 8'h0E; write 8'h02 to addr 3 → bit3 clears.
- Drive a 1/4-bit low glitch on uart_rx, then a frame with stop bit = 0: rxValid stays 0 and no flags change.
